system: RTL and testbench

//  Top-level single-clock computer: program loader, unified RAM and the team 16-bit CPU.
//  - After reset it sits idle.
//  - A start pulse makes the loader copy a program image into RAM.
//  - It then releases the CPU to execute from address 0.
//  - Programs end with a self-jump (halt). Registers and RAM are probed hierarchically.

---
 rtl/sys_pkg.sv | 46 ++++
 rtl/cpu.sv | 146 ++++++++++++++
 rtl/program_loader.sv | 44 ++++
 rtl/ram.sv | 29 ++
 rtl/system.sv | 92 +++++++++
 tb/tb_system.sv | 152 +++++++++++++++
 6 files changed

// File: rtl/sys_pkg.sv
// Shared definitions for the loader/RAM/CPU system: state encodings, default widths,
// CPU opcodes and the boot image that the loader copies into RAM.
package sys_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOADING   = 2'd1,
    EXECUTING = 2'd2
  } sys_state_e;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4
  } cpu_state_e;

  // Instruction: [15:12] opcode, [11:9] rd, [8:6] rs1, [5:3] rs2, imm6 [5:0], imm9 [8:0], imm12 [11:0]
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_LDI = 4'h4;
  localparam logic [3:0] OP_LD  = 4'h5;
  localparam logic [3:0] OP_ST  = 4'h6;
  localparam logic [3:0] OP_BEQ = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;

  // Boot program: R1=5, R2=3, R3=R1+R2, mem[20]=R3, R4=mem[20], halt at address 5
  function automatic logic [15:0] boot_word(input int unsigned k);
    case (k)
      0:       return 16'h4205;
      1:       return 16'h4403;
      2:       return 16'h0650;
      3:       return 16'h6614;
      4:       return 16'h5814;
      5:       return 16'h8005;
      default: return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/cpu.sv
// Team 16-bit multi-cycle CPU (fetch, decode, execute, memory, writeback) with an 8-entry register file.
module cpu_regs #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [2:0]            write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [2:0]            read_addr_a,
  output logic [DATA_WIDTH-1:0] read_data_a,
  input  logic [2:0]            read_addr_b,
  output logic [DATA_WIDTH-1:0] read_data_b
);

  logic [DATA_WIDTH-1:0] regs [0:7];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (write_enable) begin
      regs[write_addr] <= write_data;
    end
  end

  assign read_data_a = regs[read_addr_a];
  assign read_data_b = regs[read_addr_b];

endmodule

module cpu
  import sys_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data
);

  cpu_state_e            state;
  logic [ADDR_WIDTH-1:0] program_counter;
  logic [DATA_WIDTH-1:0] alu_out;
  logic [15:0]           ir;
  logic [DATA_WIDTH-1:0] a_val, b_val, mdr;
  logic                  take_branch;

  logic [3:0]            opcode;
  logic [2:0]            rd, rs1, rs2, read_addr_b;
  logic [DATA_WIDTH-1:0] read_a, read_b, wb_data;
  logic [DATA_WIDTH-1:0] imm6_sext, imm6_zext, imm9_sext;
  logic [ADDR_WIDTH-1:0] jump_target;
  logic                  is_mem_op, reg_write;

  assign opcode      = ir[15:12];
  assign rd          = ir[11:9];
  assign rs1         = ir[8:6];
  assign rs2         = ir[5:3];
  assign imm6_sext   = {{(DATA_WIDTH-6){ir[5]}}, ir[5:0]};
  assign imm6_zext   = DATA_WIDTH'(ir[5:0]);
  assign imm9_sext   = {{(DATA_WIDTH-9){ir[8]}}, ir[8:0]};
  assign jump_target = ADDR_WIDTH'(ir[11:0]);

  // Stores and branches read rd on the second port instead of rs2
  assign read_addr_b = (opcode == OP_ST || opcode == OP_BEQ) ? rd : rs2;
  assign is_mem_op   = (opcode == OP_LD) || (opcode == OP_ST);
  assign reg_write   = (state == WRITEBACK) &&
                       (opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LDI, OP_LD});
  assign wb_data     = (opcode == OP_LD) ? mdr : alu_out;
  assign mem_address = (state == MEMORY && is_mem_op) ? ADDR_WIDTH'(alu_out) : program_counter;

  cpu_regs #(.DATA_WIDTH(DATA_WIDTH)) regs (
    .clock       (clock),
    .reset       (reset),
    .write_enable(reg_write),
    .write_addr  (rd),
    .write_data  (wb_data),
    .read_addr_a (rs1),
    .read_data_a (read_a),
    .read_addr_b (read_addr_b),
    .read_data_b (read_b)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= FETCH;
      program_counter <= '0;
      alu_out         <= '0;
      ir              <= '0;
      a_val           <= '0;
      b_val           <= '0;
      mdr             <= '0;
      take_branch     <= 1'b0;
      mem_write       <= 1'b0;
      mem_write_data  <= '0;
    end else begin
      case (state)
        FETCH: begin
          ir    <= mem_read_data[15:0];
          state <= DECODE;
        end
        DECODE: begin
          a_val <= read_a;
          b_val <= read_b;
          state <= EXECUTE;
        end
        EXECUTE: begin
          case (opcode)
            OP_ADD:        alu_out <= a_val + b_val;
            OP_SUB:        alu_out <= a_val - b_val;
            OP_AND:        alu_out <= a_val & b_val;
            OP_OR:         alu_out <= a_val | b_val;
            OP_LDI:        alu_out <= imm9_sext;
            OP_LD, OP_ST:  alu_out <= a_val + imm6_zext;
            OP_BEQ:        alu_out <= DATA_WIDTH'(program_counter) + DATA_WIDTH'(1) + imm6_sext;
            default:       alu_out <= '0;
          endcase
          take_branch    <= (a_val == b_val);
          mem_write      <= (opcode == OP_ST);
          mem_write_data <= b_val;
          state          <= MEMORY;
        end
        MEMORY: begin
          mdr       <= mem_read_data;
          mem_write <= 1'b0;
          state     <= WRITEBACK;
        end
        WRITEBACK: begin
          if (opcode == OP_JMP)
            program_counter <= jump_target;
          else if (opcode == OP_BEQ && take_branch)
            program_counter <= ADDR_WIDTH'(alu_out);
          else
            program_counter <= program_counter + ADDR_WIDTH'(1);
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: rtl/program_loader.sv
// Copies the boot image into RAM one word per cycle after a start pulse, then pulses done.
module program_loader
  import sys_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int PROGRAM_LEN = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PROGRAM_LEN - 1);

  // mem_addr doubles as the word counter, so the last write lands exactly on LAST_ADDR
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_write <= 1'b0;
      mem_addr  <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mem_write <= 1'b1;
        mem_addr  <= '0;
      end else if (mem_write) begin
        if (mem_addr == LAST_ADDR) begin
          mem_write <= 1'b0;
          done      <= 1'b1;
        end else begin
          mem_addr <= mem_addr + ADDR_WIDTH'(1);
        end
      end
    end
  end

  assign mem_write_data = DATA_WIDTH'(boot_word(32'(mem_addr)));

endmodule

// File: rtl/ram.sv
// Unified program/data memory: synchronous write, combinational read, address wraps at MEM_DEPTH.
module ram
  import sys_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  clock,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data
);

  localparam int INDEX_WIDTH = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [DATA_WIDTH-1:0]  memory [MEM_DEPTH];
  logic [INDEX_WIDTH-1:0] index;

  assign index = INDEX_WIDTH'(32'(address) % MEM_DEPTH);

  always_ff @(posedge clock) begin
    if (write_enable) memory[index] <= write_data;
  end

  assign read_data = memory[index];

endmodule

// File: rtl/system.sv
// Top-level computer: idle until start, load the boot image into RAM, then run the CPU from address 0.
module system
  import sys_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int MEM_DEPTH   = 256,
  parameter int PROGRAM_LEN = 16
) (
  input logic clock,
  input logic reset,
  input logic start
);

  sys_state_e            system_state;
  logic                  cpu_run, cpu_reset, load_start, load_done;
  logic                  loader_write, cpu_write, ram_write;
  logic [ADDR_WIDTH-1:0] loader_addr, cpu_addr, ram_addr;
  logic [DATA_WIDTH-1:0] loader_data, cpu_wdata, ram_wdata, ram_rdata;

  assign load_start = start && (system_state == IDLE);

  // cpu_run is a dedicated flop so the CPU's active-low reset is glitch-free
  assign cpu_reset  = reset & cpu_run;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      system_state <= IDLE;
      cpu_run      <= 1'b0;
    end else begin
      case (system_state)
        IDLE:    if (start) system_state <= LOADING;
        LOADING: if (load_done) begin
          system_state <= EXECUTING;
          cpu_run      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    if (system_state == LOADING) begin
      ram_write = loader_write;
      ram_addr  = loader_addr;
      ram_wdata = loader_data;
    end else begin
      ram_write = cpu_write && (system_state == EXECUTING);
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end
  end

  program_loader #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .PROGRAM_LEN(PROGRAM_LEN)
  ) loader (
    .clock         (clock),
    .reset         (reset),
    .start         (load_start),
    .mem_write     (loader_write),
    .mem_addr      (loader_addr),
    .mem_write_data(loader_data),
    .done          (load_done)
  );

  ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) ram (
    .clock       (clock),
    .write_enable(ram_write),
    .address     (ram_addr),
    .write_data  (ram_wdata),
    .read_data   (ram_rdata)
  );

  cpu #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) cpu (
    .clock         (clock),
    .reset         (cpu_reset),
    .mem_read_data (ram_rdata),
    .mem_write     (cpu_write),
    .mem_address   (cpu_addr),
    .mem_write_data(cpu_wdata)
  );

endmodule

// File: tb/tb_system.sv
// Bench for system: loader writes scored against a queue, then a cycle model of PC/state while the boot program runs.
module tb_system;

  localparam int PLEN        = 16;
  localparam int EXEC_CYCLES = 45;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  int          tests = 0;
  int          fails = 0;
  int          load_samples = 0;
  wr_t         sb[$];
  logic [15:0] image [PLEN];

  system #(
    .MEM_DEPTH  (256),
    .PROGRAM_LEN(PLEN)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Pushes the expected writes, pulses/holds start, and scores every loader write while LOADING
  task automatic applyStimulus(input int hold_cycles, input int abort_after);
    int  samples;
    int  writes;
    wr_t want;
    sb.delete();
    for (int k = 0; k < PLEN; k++) sb.push_back('{addr: 16'(k), data: image[k]});
    start = 1'b1;
    step();
    checkOutput("state_after_start", 32'(dut.system_state), 32'd1);
    samples = 0;
    writes  = 0;
    while (dut.system_state == 2'd1 && samples < 4 * PLEN) begin
      if (samples + 1 == hold_cycles) start = 1'b0;
      samples++;
      if (dut.loader.mem_write) begin
        tests++;
        assert (sb.size() > 0)
        else begin
          fails++;
          $error("[TB] FAIL sb_extra_write: observed write to %0h, expected no write", dut.loader.mem_addr);
        end
        if (sb.size() > 0) begin
          want = sb.pop_front();
          checkOutput("load_addr", 32'(dut.loader.mem_addr), 32'(want.addr));
          checkOutput("load_data", 32'(dut.loader.mem_write_data), 32'(want.data));
        end
        writes++;
        if (writes == abort_after) return;
      end
      step();
    end
    start = 1'b0;
    load_samples = samples;
  endtask

  // Every instruction takes 5 cycles; PC advances once per instruction until the halt at address 5
  task automatic checkExecution(input int cycles, input int poke_at);
    int pc_exp;
    for (int n = 0; n < cycles; n++) begin
      pc_exp = (n / 5 > 5) ? 5 : n / 5;
      start  = (n == poke_at);
      checkOutput("exec_sys_state", 32'(dut.system_state), 32'd2);
      checkOutput("exec_pc", 32'(dut.cpu.program_counter), 32'(pc_exp));
      checkOutput("exec_cpu_state", 32'(dut.cpu.state), 32'(n % 5));
      checkOutput("exec_mem_write", 32'(dut.cpu.mem_write), 32'(n == 18));
      step();
    end
    start = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < PLEN; k++) image[k] = 16'h0000;
    image[0] = 16'h4205;
    image[1] = 16'h4403;
    image[2] = 16'h0650;
    image[3] = 16'h6614;
    image[4] = 16'h5814;
    image[5] = 16'h8005;

    #1 reset = 1'b0;
    #20;
    checkOutput("reset_sys_state", 32'(dut.system_state), 32'd0);
    checkOutput("reset_loader_write", 32'(dut.loader.mem_write), 32'd0);
    checkOutput("reset_loader_addr", 32'(dut.loader.mem_addr), 32'd0);
    checkOutput("reset_pc", 32'(dut.cpu.program_counter), 32'd0);
    checkOutput("reset_cpu_state", 32'(dut.cpu.state), 32'd0);
    for (int r = 0; r < 8; r++) checkOutput("reset_reg", 32'(dut.cpu.regs.regs[r]), 32'd0);
    reset = 1'b1;
    step();

    // First load is cut short by an asynchronous reset after six words
    applyStimulus(1, 6);
    step();
    #2 reset = 1'b0;
    #1;
    checkOutput("midload_sys_state", 32'(dut.system_state), 32'd0);
    checkOutput("midload_loader_write", 32'(dut.loader.mem_write), 32'd0);
    checkOutput("midload_loader_addr", 32'(dut.loader.mem_addr), 32'd0);
    checkOutput("midload_pc", 32'(dut.cpu.program_counter), 32'd0);
    for (int k = 0; k < 6; k++) checkOutput("partial_image", 32'(dut.ram.memory[k]), 32'(image[k]));
    #3 reset = 1'b1;
    step();
    checkOutput("idle_after_reset", 32'(dut.system_state), 32'd0);

    // Full reload with start held high for several cycles
    applyStimulus(4, 0);
    checkOutput("load_cycles", 32'(load_samples), 32'(PLEN + 1));
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    checkOutput("sys_state_executing", 32'(dut.system_state), 32'd2);
    for (int k = 0; k < PLEN; k++) checkOutput("ram_image", 32'(dut.ram.memory[k]), 32'(image[k]));

    checkExecution(EXEC_CYCLES, 12);

    checkOutput("final_r0", 32'(dut.cpu.regs.regs[0]), 32'd0);
    checkOutput("final_r1", 32'(dut.cpu.regs.regs[1]), 32'd5);
    checkOutput("final_r2", 32'(dut.cpu.regs.regs[2]), 32'd3);
    checkOutput("final_r3", 32'(dut.cpu.regs.regs[3]), 32'd8);
    checkOutput("final_r4", 32'(dut.cpu.regs.regs[4]), 32'd8);
    checkOutput("final_mem20", 32'(dut.ram.memory[20]), 32'd8);
    checkOutput("final_sys_state", 32'(dut.system_state), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
